// File: rtl/mig_axi_pkg.sv
// Shared AXI encodings and FSM state types for the on-chip AXI memory responder.
package mig_axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_t;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_mem_bram.sv
// Byte-enabled single-write / single-sync-read memory; a read of the word being written returns old data.
module axi_mem_bram #(
    parameter int unsigned DW    = 256,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW/8-1:0] wstrb,
    input  logic [DW-1:0]   wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    localparam int unsigned NB = DW / 8;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 INCR-burst responder over on-chip memory, one burst in flight per direction.
// Define MEM_THROTTLE_EN to gate awready/wready/arready with a free-running LFSR.
module axi_mem_responder
    import mig_axi_pkg::*;
#(
    parameter int unsigned C_AXI_ID_WIDTH   = 4,
    parameter int unsigned C_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_AXI_DATA_WIDTH = 256,
    parameter int unsigned MEM_DEPTH        = 1024,
    parameter logic [C_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [C_AXI_ID_WIDTH-1:0]       axi_awid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     axi_awaddr,
    input  logic [7:0]                      axi_awlen,
    input  logic [2:0]                      axi_awsize,
    input  logic [1:0]                      axi_awburst,
    input  logic                            axi_awlock,
    input  logic [3:0]                      axi_awcache,
    input  logic [2:0]                      axi_awprot,
    input  logic                            axi_awvalid,
    output logic                            axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]     axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
    input  logic                            axi_wlast,
    input  logic                            axi_wvalid,
    output logic                            axi_wready,
    output logic [C_AXI_ID_WIDTH-1:0]       axi_bid,
    output logic [1:0]                      axi_bresp,
    output logic                            axi_bvalid,
    input  logic                            axi_bready,
    input  logic [C_AXI_ID_WIDTH-1:0]       axi_arid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     axi_araddr,
    input  logic [7:0]                      axi_arlen,
    input  logic [2:0]                      axi_arsize,
    input  logic [1:0]                      axi_arburst,
    input  logic                            axi_arlock,
    input  logic [3:0]                      axi_arcache,
    input  logic [2:0]                      axi_arprot,
    input  logic                            axi_arvalid,
    output logic                            axi_arready,
    output logic [C_AXI_ID_WIDTH-1:0]       axi_rid,
    output logic [C_AXI_DATA_WIDTH-1:0]     axi_rdata,
    output logic [1:0]                      axi_rresp,
    output logic                            axi_rlast,
    output logic                            axi_rvalid,
    input  logic                            axi_rready,
    output logic                            idle
);

    localparam int unsigned NB        = C_AXI_DATA_WIDTH / 8;
    localparam int unsigned SIZE_LOG2 = $clog2(NB);
    localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);
    localparam int unsigned AW        = C_AXI_ADDR_WIDTH;
    localparam int unsigned IW        = C_AXI_ID_WIDTH;
    localparam logic [AW-1:0] DEPTH_A = AW'(MEM_DEPTH);
    localparam logic [2:0]    SIZE_OK = 3'(SIZE_LOG2);

    logic unused_sideband;
    assign unused_sideband = ^{axi_awlock, axi_awcache, axi_awprot,
                               axi_arlock, axi_arcache, axi_arprot};

    logic aw_gate, w_gate, ar_gate;
`ifdef MEM_THROTTLE_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign aw_gate = lfsr[0];
    assign w_gate  = lfsr[5];
    assign ar_gate = lfsr[10];
`else
    assign aw_gate = 1'b1;
    assign w_gate  = 1'b1;
    assign ar_gate = 1'b1;
`endif

    // ---------------- write channel ----------------
    wr_state_t     w_state;
    logic [IW-1:0] w_id;
    logic [AW-1:0] w_idx;
    logic [7:0]    w_len, w_cnt;
    logic          w_hdr_err, w_err;
    logic [IW-1:0] b_id;
    logic [1:0]    b_resp;

    logic aw_hs, w_hs, w_last_beat, w_in_range, w_beat_err, aw_hdr_err;

    assign axi_awready = (w_state == W_IDLE) && aw_gate;
    assign axi_wready  = (w_state == W_DATA) && w_gate;
    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_in_range  = (w_idx < DEPTH_A);
    assign w_beat_err  = !w_in_range || (axi_wlast != w_last_beat);
    assign aw_hdr_err  = (axi_awburst != BURST_INCR) || (axi_awsize != SIZE_OK);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            w_id      <= '0;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_hdr_err <= 1'b0;
            w_err     <= 1'b0;
            b_id      <= '0;
            b_resp    <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    w_id      <= axi_awid;
                    w_idx     <= (axi_awaddr - BASE_ADDR) >> SIZE_LOG2;
                    w_len     <= axi_awlen;
                    w_cnt     <= '0;
                    w_hdr_err <= aw_hdr_err;
                    w_err     <= aw_hdr_err;
                    w_state   <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    w_idx <= w_idx + 1'b1;
                    w_cnt <= w_cnt + 8'd1;
                    w_err <= w_err | w_beat_err;
                    // burst length is governed by awlen; wlast only feeds the error flag
                    if (w_last_beat) begin
                        b_id    <= w_id;
                        b_resp  <= resp_of(w_err | w_beat_err);
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (axi_bready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign axi_bvalid = (w_state == W_RESP);
    assign axi_bid    = b_id;
    assign axi_bresp  = b_resp;

    // ---------------- read channel ----------------
    rd_state_t     r_state;
    logic [IW-1:0] r_id;
    logic [AW-1:0] r_idx;
    logic [7:0]    r_len, r_cnt;
    logic          r_hdr_err, r_oor, r_last;
    logic [1:0]    r_resp;

    logic ar_hs, r_in_range;
    logic [C_AXI_DATA_WIDTH-1:0] mem_rdata;

    assign axi_arready = (r_state == R_IDLE) && ar_gate;
    assign ar_hs       = axi_arvalid && axi_arready;
    assign r_in_range  = (r_idx < DEPTH_A);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            r_id      <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_hdr_err <= 1'b0;
            r_oor     <= 1'b0;
            r_last    <= 1'b0;
            r_resp    <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    r_id      <= axi_arid;
                    r_idx     <= (axi_araddr - BASE_ADDR) >> SIZE_LOG2;
                    r_len     <= axi_arlen;
                    r_cnt     <= '0;
                    r_hdr_err <= (axi_arburst != BURST_INCR) || (axi_arsize != SIZE_OK);
                    r_state   <= R_FETCH;
                end
                R_FETCH: begin
                    r_oor   <= !r_in_range;
                    r_resp  <= resp_of(r_hdr_err || !r_in_range);
                    r_last  <= (r_cnt == r_len);
                    r_state <= R_DATA;
                end
                R_DATA: if (axi_rready) begin
                    if (r_last) begin
                        r_state <= R_IDLE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_cnt   <= r_cnt + 8'd1;
                        r_state <= R_FETCH;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // memory output only reloads in R_FETCH, so it holds while a beat is stalled
    assign axi_rvalid = (r_state == R_DATA);
    assign axi_rid    = r_id;
    assign axi_rdata  = (axi_rvalid && !r_oor) ? mem_rdata : '0;
    assign axi_rresp  = axi_rvalid ? r_resp : RESP_OKAY;
    assign axi_rlast  = axi_rvalid && r_last;

    assign idle = (w_state == W_IDLE) && (r_state == R_IDLE);

    // writes of a burst with a bad burst type or size are dropped entirely
    axi_mem_bram #(
        .DW    (C_AXI_DATA_WIDTH),
        .DEPTH (MEM_DEPTH),
        .AW    (MEM_AW)
    ) u_bram (
        .clk   (clk),
        .we    (w_hs && w_in_range && !w_hdr_err),
        .waddr (w_idx[MEM_AW-1:0]),
        .wstrb (axi_wstrb),
        .wdata (axi_wdata),
        .re    ((r_state == R_FETCH) && r_in_range),
        .raddr (r_idx[MEM_AW-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: stimulus pushes expected B/R responses, a monitor pops and compares.
module tb_axi_mem_responder;
    import mig_axi_pkg::*;

    localparam int IW    = 4;
    localparam int AW    = 64;
    localparam int DW    = 256;
    localparam int NB    = 32;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [IW-1:0] axi_awid = '0, axi_arid = '0, axi_bid, axi_rid;
    logic [AW-1:0] axi_awaddr = '0, axi_araddr = '0;
    logic [7:0]    axi_awlen = '0, axi_arlen = '0;
    logic [2:0]    axi_awsize = 3'd5, axi_arsize = 3'd5, axi_awprot = '0, axi_arprot = '0;
    logic [1:0]    axi_awburst = BURST_INCR, axi_arburst = BURST_INCR, axi_bresp, axi_rresp;
    logic          axi_awlock = 1'b0, axi_arlock = 1'b0;
    logic [3:0]    axi_awcache = '0, axi_arcache = '0;
    logic          axi_awvalid = 1'b0, axi_arvalid = 1'b0, axi_wvalid = 1'b0, axi_wlast = 1'b0;
    logic          axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast, idle;
    logic          axi_bready = 1'b1, axi_rready = 1'b1;
    logic [DW-1:0] axi_wdata = '0, axi_rdata;
    logic [NB-1:0] axi_wstrb = '0;

    axi_mem_responder #(
        .C_AXI_ID_WIDTH   (IW),
        .C_AXI_ADDR_WIDTH (AW),
        .C_AXI_DATA_WIDTH (DW),
        .MEM_DEPTH        (DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
        .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .idle(idle)
    );

    typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t bq[$];
    r_exp_t rq[$];
    int  checks = 0;
    int  errors = 0;
    bit  sb_off = 1'b0;
    bit  r_throttle = 1'b0;

    localparam logic [DW-1:0] T2_WORD = {{224{1'b1}}, 32'hDEADBEEF};

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // rready pattern: high one cycle in four when throttled, so R beats stall
    initial begin
        int unsigned cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            axi_rready = r_throttle ? (cnt % 4 == 3) : 1'b1;
        end
    end

    // monitor: pops expectations on B/R handshakes and checks payload stability under backpressure
    initial begin
        logic b_hold, r_hold;
        logic [IW+1:0] b_snap;
        logic [DW+IW+2:0] r_snap;
        b_exp_t be;
        r_exp_t re;
        b_hold = 1'b0;
        r_hold = 1'b0;
        b_snap = '0;
        r_snap = '0;
        forever begin
            @(negedge clk);
            if (rst || sb_off) begin
                b_hold = 1'b0;
                r_hold = 1'b0;
            end else begin
                if (b_hold) begin
                    chk("b_held_valid", DW'(axi_bvalid), DW'(1));
                    chk("b_held_payload", DW'({axi_bid, axi_bresp}), DW'(b_snap));
                end
                if (r_hold) begin
                    chk("r_held_valid", DW'(axi_rvalid), DW'(1));
                    chk("r_held_payload", DW'({axi_rid, axi_rdata, axi_rresp, axi_rlast}), DW'(r_snap));
                end
                if (axi_bvalid && axi_bready) begin
                    if (bq.size() == 0) begin
                        chk("b_unexpected", DW'(axi_bvalid), DW'(0));
                    end else begin
                        be = bq.pop_front();
                        chk("bid", DW'(axi_bid), DW'(be.id));
                        chk("bresp", DW'(axi_bresp), DW'(be.resp));
                    end
                end
                if (axi_rvalid && axi_rready) begin
                    if (rq.size() == 0) begin
                        chk("r_unexpected", DW'(axi_rvalid), DW'(0));
                    end else begin
                        re = rq.pop_front();
                        chk("rid", DW'(axi_rid), DW'(re.id));
                        chk("rdata", axi_rdata, re.data);
                        chk("rresp", DW'(axi_rresp), DW'(re.resp));
                        chk("rlast", DW'(axi_rlast), DW'(re.last));
                    end
                end
                b_hold = axi_bvalid && !axi_bready;
                b_snap = {axi_bid, axi_bresp};
                r_hold = axi_rvalid && !axi_rready;
                r_snap = {axi_rid, axi_rdata, axi_rresp, axi_rlast};
            end
        end
    end

    task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        bit ok;
        int n;
        n = 0;
        axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awsize = 3'd5; axi_awburst = burst;
        axi_awvalid = 1'b1;
        do begin
            @(negedge clk); ok = axi_awready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 200);
        axi_awvalid = 1'b0;
        chk("aw_handshake", DW'(ok), DW'(1));
    endtask

    task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        bit ok;
        int n;
        n = 0;
        axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arsize = 3'd5; axi_arburst = burst;
        axi_arvalid = 1'b1;
        do begin
            @(negedge clk); ok = axi_arready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 200);
        axi_arvalid = 1'b0;
        chk("ar_handshake", DW'(ok), DW'(1));
    endtask

    task automatic send_w(input logic [DW-1:0] data, input logic [NB-1:0] strb, input logic last);
        bit ok;
        int n;
        n = 0;
        axi_wdata = data; axi_wstrb = strb; axi_wlast = last; axi_wvalid = 1'b1;
        do begin
            @(negedge clk); ok = axi_wready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 200);
        axi_wvalid = 1'b0;
        axi_wlast = 1'b0;
        if (!ok) chk("w_handshake", DW'(ok), DW'(1));
    endtask

    task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int wlast_at, input logic [NB-1:0] strb,
                            input logic [DW-1:0] dbase, input logic [1:0] resp);
        bq.push_back('{id: id, resp: resp});
        send_aw(id, addr, len, burst);
        for (int k = 0; k <= int'(len); k++) begin
            send_w(dbase + DW'(k), strb, k == wlast_at);
        end
    endtask

    task automatic push_r(input logic [IW-1:0] id, input logic [DW-1:0] data,
                          input logic [1:0] resp, input logic last);
        rq.push_back('{id: id, data: data, resp: resp, last: last});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(bq.size() == 0 && rq.size() == 0 && idle) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", DW'(bq.size() + rq.size()), DW'(0));
        chk("drain_idle", DW'(idle), DW'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", DW'(axi_awready), DW'(1));
        chk("rst_arready", DW'(axi_arready), DW'(1));
        chk("rst_wready", DW'(axi_wready), DW'(0));
        chk("rst_bvalid", DW'(axi_bvalid), DW'(0));
        chk("rst_rvalid", DW'(axi_rvalid), DW'(0));
        chk("rst_rlast", DW'(axi_rlast), DW'(0));
        chk("rst_resp", DW'({axi_bresp, axi_rresp}), DW'(0));
        chk("rst_ids", DW'({axi_bid, axi_rid}), DW'(0));
        chk("rst_rdata", axi_rdata, '0);
        chk("rst_idle", DW'(idle), DW'(1));
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: 8-beat write of k, read back
        do_write(4'd1, 64'd0, 8'd7, BURST_INCR, 7, '1, '0, RESP_OKAY);
        wait_drain();
        for (int k = 0; k < 8; k++) push_r(4'd2, DW'(k), RESP_OKAY, k == 7);
        send_ar(4'd2, 64'd0, 8'd7, BURST_INCR);
        wait_drain();

        // 2: partial strobe over all-ones word 3
        do_write(4'd3, 64'd96, 8'd0, BURST_INCR, 0, '1, '1, RESP_OKAY);
        do_write(4'd4, 64'd96, 8'd0, BURST_INCR, 0, NB'(32'h0000_000F), DW'(32'hDEADBEEF), RESP_OKAY);
        wait_drain();
        push_r(4'd5, T2_WORD, RESP_OKAY, 1'b1);
        send_ar(4'd5, 64'd96, 8'd0, BURST_INCR);
        wait_drain();

        // 3: read crossing the top of memory
        do_write(4'd6, 64'(1022 * 32), 8'd1, BURST_INCR, 1, '1, DW'(16'hA00), RESP_OKAY);
        wait_drain();
        push_r(4'd7, DW'(16'hA00), RESP_OKAY, 1'b0);
        push_r(4'd7, DW'(16'hA01), RESP_OKAY, 1'b0);
        push_r(4'd7, '0, RESP_SLVERR, 1'b0);
        push_r(4'd7, '0, RESP_SLVERR, 1'b1);
        send_ar(4'd7, 64'(1022 * 32), 8'd3, BURST_INCR);
        wait_drain();

        // 4: early wlast, then FIXED burst
        do_write(4'd8, 64'(64 * 32), 8'd7, BURST_INCR, 3, '1, DW'(16'h500), RESP_SLVERR);
        wait_drain();
        do_write(4'd9, 64'(80 * 32), 8'd0, 2'b00, 0, '1, '0, RESP_SLVERR);
        wait_drain();

        // 5: B backpressure, throttled R
        axi_bready = 1'b0;
        do_write(4'd11, 64'(200 * 32), 8'd0, BURST_INCR, 0, '1, '0, RESP_OKAY);
        repeat (20) @(posedge clk);
        #1;
        chk("b_waiting", DW'(axi_bvalid), DW'(1));
        axi_bready = 1'b1;
        wait_drain();
        r_throttle = 1'b1;
        for (int k = 4; k < 8; k++) push_r(4'd12, DW'(k), RESP_OKAY, k == 7);
        send_ar(4'd12, 64'(4 * 32), 8'd3, BURST_INCR);
        wait_drain();
        r_throttle = 1'b0;
        @(posedge clk); #1;

        // 6: concurrent long bursts aborted by reset
        sb_off = 1'b1;
        fork
            send_aw(4'd13, 64'(256 * 32), 8'd255, BURST_INCR);
            send_ar(4'd14, 64'd0, 8'd255, BURST_INCR);
        join
        axi_wdata = '1; axi_wstrb = '1; axi_wlast = 1'b0; axi_wvalid = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_rvalid", DW'(axi_rvalid), DW'(0));
        chk("abort_bvalid", DW'(axi_bvalid), DW'(0));
        chk("abort_wready", DW'(axi_wready), DW'(0));
        chk("abort_readies", DW'({axi_awready, axi_arready}), DW'(2'b11));
        chk("abort_rdata", axi_rdata, '0);
        chk("abort_idle", DW'(idle), DW'(1));
        axi_wvalid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        sb_off = 1'b0;

        // memory survives reset
        push_r(4'd15, T2_WORD, RESP_OKAY, 1'b1);
        send_ar(4'd15, 64'd96, 8'd0, BURST_INCR);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
